// File: rtl/entropy_pkg.sv
// Shared register map and status layout for the entropy counter.
package entropy_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned BIT_CNT_W   = 5;
    localparam int unsigned ADDR_W      = 2;

    // Avalon-MM word addresses
    typedef enum logic [ADDR_W-1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_STATUS  = 2'd1,
        ADDR_LASTCNT = 2'd2,
        ADDR_RSVD    = 2'd3
    } reg_addr_e;

    // Status word bit positions
    localparam int unsigned STATUS_BIT_CNT_LSB  = 0;
    localparam int unsigned STATUS_VALID_BIT    = 5;
    localparam int unsigned STATUS_OVERFLOW_BIT = 6;

    // Assemble the status word; every unused bit reads as zero.
    function automatic logic [DATA_W-1:0] pack_status(
        input logic                 overflow,
        input logic                 valid,
        input logic [BIT_CNT_W-1:0] bit_cnt
    );
        logic [DATA_W-1:0] word;
        word                                        = '0;
        word[STATUS_OVERFLOW_BIT]                   = overflow;
        word[STATUS_VALID_BIT]                      = valid;
        word[STATUS_BIT_CNT_LSB +: BIT_CNT_W]       = bit_cnt;
        return word;
    endfunction

endpackage

// File: rtl/entropy_edge_sync.sv
// Two-flop synchronizer for the ring oscillator plus a rising-edge detector.
module entropy_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic ring_osc_in,
    output logic rise_c
);

    logic stage1;
    logic stage2;
    logic stage3;

    // Synchronizer chain; stage3 is the delayed copy used for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage1 <= 1'b0;
            stage2 <= 1'b0;
            stage3 <= 1'b0;
        end else begin
            stage1 <= ring_osc_in;
            stage2 <= stage1;
            stage3 <= stage2;
        end
    end

    assign rise_c = stage2 & ~stage3;

endmodule

// File: rtl/entropy_counter.sv
// Counts ring-oscillator edges per sampling window, harvests the count LSB
// as one random bit per window and exposes assembled 32-bit words over Avalon-MM.
module entropy_counter
    import entropy_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned COUNT_WIDTH   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ring_osc_in,
    input  logic              entropy_counter_enable,
    input  logic              entropy_counter_clear,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    output logic [DATA_W-1:0] avs_readdata
);

    localparam int unsigned WIN_W     = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int unsigned PENDING_W = DATA_W - 1;
    localparam logic [WIN_W-1:0]     WIN_LAST     = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = BIT_CNT_W'(DATA_W - 1);

    logic                   rise_c;
    logic [WIN_W-1:0]       window_cnt;
    logic [COUNT_WIDTH-1:0] edge_cnt;
    // The 32nd bit of a word never needs storage: it comes straight from the
    // edge counter on the completing cycle, so only 31 older bits are held.
    logic [PENDING_W-1:0]   pending_bits;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [COUNT_WIDTH-1:0] last_count;
    logic [DATA_W-1:0]      data_reg;
    logic                   valid;
    logic                   overflow;

    logic                   active_c;
    logic                   last_cycle_c;
    logic                   word_done_c;
    logic                   data_read_c;
    logic [COUNT_WIDTH-1:0] edge_next_c;
    logic [DATA_W-1:0]      word_next_c;

    entropy_edge_sync u_edge_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .ring_osc_in (ring_osc_in),
        .rise_c      (rise_c)
    );

    // Next edge count (saturating), window-end detection and the assembled word
    always_comb begin
        active_c     = entropy_counter_enable & ~entropy_counter_clear;
        last_cycle_c = active_c && (window_cnt == WIN_LAST);
        edge_next_c  = edge_cnt;
        if (rise_c && (edge_cnt != '1)) begin
            edge_next_c = edge_cnt + COUNT_WIDTH'(1);
        end
        word_next_c  = {pending_bits, edge_next_c[0]};
        word_done_c  = last_cycle_c && (bit_cnt == BIT_CNT_LAST);
        data_read_c  = avs_read && (avs_address == ADDR_DATA);
    end

    // Window, edge, bit and shift state; holds while disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            window_cnt   <= '0;
            edge_cnt     <= '0;
            pending_bits <= '0;
            bit_cnt      <= '0;
            last_count   <= '0;
        end else if (entropy_counter_clear) begin
            window_cnt   <= '0;
            edge_cnt     <= '0;
            pending_bits <= '0;
            bit_cnt      <= '0;
            last_count   <= '0;
        end else if (active_c) begin
            if (last_cycle_c) begin
                window_cnt   <= '0;
                edge_cnt     <= '0;
                pending_bits <= word_next_c[PENDING_W-1:0];
                bit_cnt      <= bit_cnt + BIT_CNT_W'(1);
                last_count   <= edge_next_c;
            end else begin
                window_cnt   <= window_cnt + WIN_W'(1);
                edge_cnt     <= edge_next_c;
            end
        end
    end

    // Output word hand-off: a concurrent data read frees the slot for the new word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else if (entropy_counter_clear) begin
            data_reg <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else if (word_done_c) begin
            if (!valid || data_read_c) begin
                data_reg <= word_next_c;
                valid    <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (data_read_c) begin
            valid <= 1'b0;
        end
    end

    // Register read mux with one-cycle latency; holds when no read is issued
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            case (avs_address)
                ADDR_DATA:    avs_readdata <= data_reg;
                ADDR_STATUS:  avs_readdata <= pack_status(overflow, valid, bit_cnt);
                ADDR_LASTCNT: avs_readdata <= DATA_W'(last_count);
                default:      avs_readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_entropy_counter.sv
// Self-checking bench for entropy_counter with a behavioural reference model.
module tb_entropy_counter;

    localparam int unsigned WIN = 8;
    localparam int unsigned CW  = 16;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        osc      = 1'b0;
    logic        enable   = 1'b0;
    logic        clear    = 1'b0;
    logic        avs_read = 1'b0;
    logic [1:0]  avs_address = 2'd0;
    logic [31:0] avs_readdata;

    int n_cmp  = 0;
    int n_fail = 0;

    entropy_counter #(
        .WINDOW_CYCLES (WIN),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .ring_osc_in            (osc),
        .entropy_counter_enable (enable),
        .entropy_counter_clear  (clear),
        .avs_address            (avs_address),
        .avs_read               (avs_read),
        .avs_readdata           (avs_readdata)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_edges = 0;
    int          m_win   = 0;
    int          m_nbits = 0;
    logic [31:0] m_word  = '0;
    logic [31:0] m_data  = '0;
    logic [31:0] m_rdata = '0;
    logic [CW-1:0] m_last = '0;
    bit          m_valid = 1'b0;
    bit          m_ovf   = 1'b0;
    // osc samples taken at previous edges, most recent first
    bit          osc_q[$] = '{1'b0, 1'b0, 1'b0};

    function automatic logic [31:0] model_reg(input logic [1:0] a);
        case (a)
            2'd0:    return m_data;
            2'd1:    return {25'd0, m_ovf, m_valid, 5'(m_nbits)};
            2'd2:    return 32'(m_last);
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural model: an oscillator rise is counted two clocks after it is sampled
    always @(posedge clk or negedge reset_n) begin : model
        bit rise;
        bit rd0;
        bit done;
        if (!reset_n) begin
            m_edges = 0; m_win = 0; m_nbits = 0;
            m_word = '0; m_data = '0; m_rdata = '0; m_last = '0;
            m_valid = 1'b0; m_ovf = 1'b0;
            osc_q = '{1'b0, 1'b0, 1'b0};
        end else begin
            rd0 = avs_read && (avs_address == 2'd0);
            if (avs_read) m_rdata = model_reg(avs_address);
            rise = osc_q[1] && !osc_q[2];
            done = 1'b0;
            if (clear) begin
                m_edges = 0; m_win = 0; m_nbits = 0;
                m_word = '0; m_data = '0; m_last = '0;
                m_valid = 1'b0; m_ovf = 1'b0;
            end else begin
                if (enable) begin
                    if (rise && m_edges < 65535) m_edges++;
                    m_win++;
                    if (m_win == WIN) begin
                        m_win   = 0;
                        m_last  = CW'(m_edges);
                        m_word  = {m_word[30:0], m_edges[0]};
                        m_edges = 0;
                        m_nbits++;
                        if (m_nbits == 32) begin
                            m_nbits = 0;
                            done    = 1'b1;
                        end
                    end
                end
                if (done) begin
                    if (!m_valid || rd0) begin
                        m_data  = m_word;
                        m_valid = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end else if (rd0) begin
                    m_valid = 1'b0;
                end
            end
            osc_q.push_front(osc);
            void'(osc_q.pop_back());
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input string tag, output logic [31:0] val);
        logic [31:0] exp;
        avs_read    = 1'b1;
        avs_address = a;
        exp         = model_reg(a);
        tick();
        avs_read    = 1'b0;
        check(tag, avs_readdata, exp);
        val = avs_readdata;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            osc = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    // Deterministic windows: 3 rises each, or alternating 2/3 starting with 2
    task automatic windows_pattern(input int nwin, input bit alt);
        for (int w = 0; w < nwin; w++) begin
            int nr;
            nr = (alt && (w % 2 == 0)) ? 2 : 3;
            for (int c = 0; c < int'(WIN); c++) begin
                osc = ((c % 2 == 0) && (c / 2 < nr)) ? 1'b1 : 1'b0;
                tick();
            end
        end
        osc = 1'b0;
    endtask

    task automatic pulse_clear();
        enable = 1'b0;
        clear  = 1'b1;
        tick();
        clear  = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] v;
        logic [31:0] word1;
        logic [31:0] word2;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_readdata", avs_readdata, 32'd0);
        reset_n = 1'b1;
        tick();
        rd(2'd0, "reset_data", v);
        check("reset_data_zero", v, 32'd0);
        rd(2'd1, "reset_status", v);
        check("reset_status_zero", v, 32'd0);

        // Three edges in every window
        enable = 1'b1;
        windows_pattern(32, 1'b0);
        enable = 1'b0;
        rd(2'd1, "all3_status", v);
        check("all3_status_const", v, 32'h0000_0020);
        rd(2'd0, "all3_data", v);
        check("all3_data_const", v, 32'hFFFF_FFFF);
        rd(2'd2, "all3_lastcnt", v);
        check("all3_lastcnt_const", v, 32'd3);
        tick();
        check("readdata_hold", avs_readdata, 32'd3);
        rd(2'd3, "addr3", v);
        check("addr3_const", v, 32'd0);
        rd(2'd1, "valid_cleared", v);
        check("valid_cleared_const", v, 32'd0);

        // Alternating 2/3 edges per window
        pulse_clear();
        enable = 1'b1;
        windows_pattern(32, 1'b1);
        enable = 1'b0;
        rd(2'd0, "alt_data", v);
        check("alt_data_const", v, 32'h5555_5555);

        // Two words without reading: overflow, first word kept
        pulse_clear();
        enable = 1'b1;
        word1  = '0;
        for (int i = 0; i < 64 * int'(WIN); i++) begin
            osc = 1'($urandom_range(0, 1));
            tick();
            if (i == 32 * int'(WIN) - 1) word1 = m_data;
        end
        enable = 1'b0;
        rd(2'd1, "ovf_status", v);
        check("ovf_status_const", v, 32'h0000_0060);
        rd(2'd0, "ovf_data", v);
        check("ovf_data_first", v, word1);
        pulse_clear();
        rd(2'd1, "clr_status", v);
        check("clr_status_const", v, 32'd0);
        rd(2'd0, "clr_data", v);
        check("clr_data_const", v, 32'd0);

        // Enable gap mid-window with the oscillator still toggling
        enable = 1'b1;
        run(13);
        enable = 1'b0;
        run(20);
        enable = 1'b1;
        run(100);
        enable = 1'b0;
        rd(2'd1, "gap_status", v);
        check("gap_bitcnt", 32'(v[4:0]), 32'd14);
        rd(2'd2, "gap_lastcnt", v);

        // Data read on the exact completion cycle of the second word
        pulse_clear();
        enable = 1'b1;
        for (int i = 0; i < 64 * int'(WIN); i++) begin
            osc = 1'($urandom_range(0, 1));
            if (i == 64 * int'(WIN) - 1) begin
                avs_read    = 1'b1;
                avs_address = 2'd0;
            end
            tick();
            if (i == 32 * int'(WIN) - 1) word1 = m_data;
        end
        avs_read = 1'b0;
        enable   = 1'b0;
        check("coincide_rdata", avs_readdata, word1);
        word2 = m_data;
        rd(2'd1, "coincide_status", v);
        check("coincide_status_const", v, 32'h0000_0020);
        rd(2'd0, "coincide_data", v);
        check("coincide_data_word2", v, word2);

        // Asynchronous reset between clock edges, mid-window
        pulse_clear();
        enable = 1'b1;
        run(11);
        rd(2'd1, "pre_rst_status", v);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_rdata", avs_readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run(7);
        rd(2'd1, "post_rst_7", v);
        check("post_rst_7_bitcnt", 32'(v[4:0]), 32'd0);
        rd(2'd1, "post_rst_8", v);
        check("post_rst_8_bitcnt", 32'(v[4:0]), 32'd1);
        enable = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/entropy_counter.md
ENTROPY_COUNTER -- requirements
Module: entropy_counter

Interface
REQ-001 The module SHALL have parameter WINDOW_CYCLES, default 1024, meaning clk cycles per sampling window (legal range 2..65536).
REQ-002 The module SHALL have parameter COUNT_WIDTH, default 16, meaning width of the per-window edge counter.
REQ-003 clk  input  1  the single clock for all logic.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ring_osc_in  input  1  free-running ring oscillator output, asynchronous to clk.
REQ-006 entropy_counter_enable  input  1  level; counting runs while high.
REQ-007 entropy_counter_clear  input  1  level; synchronous clear of all sampling state while high.
REQ-008 avs_address  input  2  Avalon-MM slave word address.
REQ-009 avs_read  input  1  Avalon-MM read strobe.
REQ-010 avs_readdata  output  32  Avalon-MM read data, fixed read latency 1.

Function
REQ-011 ring_osc_in SHALL pass through a 2-flop synchronizer and then a third flop for edge detection; a rising edge is flagged when stage2=1 and stage3=0.
REQ-012 While enable=1 and clear=0, the window counter SHALL count 0..WINDOW_CYCLES-1 and then wrap to 0.
REQ-013 While enable=1 and clear=0, each flagged edge SHALL increment the edge counter, which saturates at all-ones.
REQ-014 On the last window cycle (window counter = WINDOW_CYCLES-1), the following SHALL occur:
- LSB of (edge count including that cycle's edge) shifted into the 32-bit shift register at bit 0, older bits moving toward bit 31;
- that full count latched into last_count;
- edge counter reset to 0;
- bit counter (0..31) incremented.
REQ-015 When the 32nd bit is shifted (bit counter wraps 31->0):
- if valid=0: the assembled word SHALL be loaded into data_reg and valid set to 1;
- if valid=1 and no concurrent data read: the new word SHALL be dropped and the sticky overflow flag set.
REQ-016 With enable=0, the window, edge, bit and shift state SHALL hold, and edges SHALL be ignored.
REQ-017 clear=1 SHALL override enable and zero the following: window counter, edge counter, shift register, bit counter, data_reg, last_count, valid and overflow.
REQ-018 Register map (readdata returned the cycle after avs_read):
- address 0: data_reg;
- address 1: {overflow at bit 6, valid at bit 5, bit counter at bits 4:0}, all other bits 0;
- address 2: last_count zero-extended;
- address 3: constant 0.
REQ-019 A read of address 0 SHALL clear valid in the cycle following the read strobe, and SHALL return the pre-read data_reg.
REQ-020 If a read of address 0 coincides with word completion, readdata SHALL be the old word, data_reg SHALL load the new word, valid SHALL remain 1, and overflow SHALL be unchanged.
REQ-021 avs_readdata SHALL be held at its last value when no read is issued.

Reset
REQ-022 reset_n low SHALL asynchronously clear the following to 0: synchronizer flops, all counters, shift register, data_reg, last_count, valid, overflow and avs_readdata.
REQ-023 Reset deassertion mid-window SHALL restart sampling from window count 0 with no partial bits retained.

Structure
REQ-024 The register address constants (DATA=0, STATUS=1, LASTCNT=2) and the status bit positions SHALL live in a shared package entropy_pkg.
REQ-025 The synchronizer plus edge detector SHALL be a sub-module named entropy_edge_sync; all other logic SHALL be in entropy_counter.

Verification (WINDOW_CYCLES=8, COUNT_WIDTH=16)
REQ-026 Feed 3 osc edges per window for 32 windows with enable=1 -> address 0 reads 0xFFFFFFFF, status valid=1, address 2 reads 3.
REQ-027 Alternate 2 and 3 edges per window (first window 2) for 32 windows -> data 0x55555555.
REQ-028 Complete 2 words without reading -> status overflow=1, data equals first word; then pulse clear -> status reads 0 and data reads 0.
REQ-029 Drop enable for 20 cycles mid-window while toggling osc, then raise it -> the bit counter advances exactly as if the gap were absent.
REQ-030 Issue a data read on the exact cycle the second word completes -> readdata returns word 1, then data returns word 2 with valid=1 and overflow=0.
REQ-031 Assert reset_n low asynchronously between clk edges mid-window -> all outputs read 0 immediately, and the first bit after release appears 8 cycles after enable.
